// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states and
// small decode helpers used by the datapath and the lane aligner.
package lsu_pkg;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    DATA = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_e;

  // Only meaningful for defined op codes: bit 3 separates stores from loads.
  function automatic logic is_store(input logic [3:0] op);
    return op[3];
  endfunction

  // LBU/LHU carry bit 2; signed loads do not.
  function automatic logic is_unsigned(input logic [3:0] op);
    return op[2];
  endfunction

  function automatic logic op_defined(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Halfword accesses need an even address, word accesses a 4-byte aligned one.
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lo[0];
      OP_LW, OP_SW:         return lo != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends a load lane from a
// memory word, and merges store data into the selected lane of a word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and build both the load result and the merged store word.
  always_comb begin
    byte_sel     = word_i[{byte_off_i, 3'b000} +: 8];
    half_sel     = word_i[{byte_off_i[1], 4'b0000} +: 16];
    load_data_o  = word_i;
    store_data_o = wdata_i;
    case (op_i)
      OP_LB, OP_LBU:
        load_data_o = {{24{byte_sel[7] & ~is_unsigned(op_i)}}, byte_sel};
      OP_LH, OP_LHU:
        load_data_o = {{16{half_sel[15] & ~is_unsigned(op_i)}}, half_sel};
      OP_SB: begin
        store_data_o = word_i;
        store_data_o[{byte_off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      OP_SH: begin
        store_data_o = word_i;
        store_data_o[{byte_off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_data_o  = word_i;
        store_data_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit in front of a word-addressed memory with a
// one-cycle registered read and full-word writes. Sub-word stores are done
// as read-modify-write; bad requests are answered without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] memAddress,
  output logic              memWriteEnable,
  output logic [31:0]       memDataIn,
  input  logic [31:0]       memDataOut
);

  localparam logic [ADDR_W-1:0] MEM_WORDS_L = ADDR_W'(MEM_WORDS);

  lsu_state_e        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              error_q, error_d;

  logic [ADDR_W-1:0] word_idx;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       store_data;

  assign word_idx = {2'b00, addr_q[ADDR_W-1:2]};
  assign req_err  = ~op_defined(req_op)
                  | misaligned(req_op, req_addr[1:0])
                  | ({2'b00, req_addr[ADDR_W-1:2]} >= MEM_WORDS_L);

  lsu_lane_align u_align (
    .op_i         (op_q),
    .byte_off_i   (addr_q[1:0]),
    .word_i       (memDataOut),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_data_o (store_data)
  );

  // State and latched request registers; reset discards any request in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Next-state and request latching: accept in IDLE, capture load data in DATA.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          error_d = req_err;
          if (req_err)              state_d = RESP;
          else if (req_op == OP_SW) state_d = WR;
          else                      state_d = RD;
        end
      end
      RD:   state_d = DATA;
      DATA: begin
        if (!is_store(op_q)) rdata_d = load_data;
        state_d = RESP;
      end
      WR:   state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and memory port outputs decoded from the current state.
  always_comb begin
    req_ready      = (state_q == IDLE);
    resp_valid     = (state_q == RESP);
    resp_rdata     = rdata_q;
    resp_error     = error_q;
    memAddress     = '0;
    memWriteEnable = 1'b0;
    memDataIn      = '0;
    case (state_q)
      RD: memAddress = word_idx;
      DATA: begin
        memAddress = word_idx;
        if (is_store(op_q)) begin
          memWriteEnable = 1'b1;
          memDataIn      = store_data;
        end
      end
      WR: begin
        memAddress     = word_idx;
        memWriteEnable = 1'b1;
        memDataIn      = wdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written stall and
// reset-abort sequences, then random requests against an arithmetic model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] memAddress;
  logic        memWriteEnable;
  logic [31:0] memDataIn;
  logic [31:0] memDataOut;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1024), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .memAddress(memAddress), .memWriteEnable(memWriteEnable),
    .memDataIn(memDataIn), .memDataOut(memDataOut)
  );

  // Downstream memory: registered read, full-word write, no reset.
  logic [31:0] mem [0:1023];
  logic [31:0] mem_rd_q;
  logic        mem_clear;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else begin
      if (memWriteEnable && memAddress < 32'd1024) mem[memAddress[9:0]] <= memDataIn;
      mem_rd_q <= mem[memAddress[9:0]];
    end
  end
  assign memDataOut = mem_rd_q;

  // Count write-strobe cycles and remember the last write.
  int          wr_count = 0;
  logic [31:0] wr_addr_seen, wr_data_seen;
  always @(negedge clk) begin
    if (memWriteEnable === 1'b1) begin
      wr_count     = wr_count + 1;
      wr_addr_seen = memAddress;
      wr_data_seen = memDataIn;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference memory contents as the specification's rules say they should evolve.
  logic [31:0] ref_mem [0:1023];

  function automatic void model(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rdata,
                                output logic err, output int lat, output int nwr,
                                output logic [31:0] widx, output logic [31:0] wval);
    int size, sh;
    logic [31:0] idx, w, mask, v;
    rdata = 0; err = 0; lat = 0; nwr = 0; widx = 0; wval = 0;
    case (op)
      4'd0, 4'd4, 4'd8: size = 1;
      4'd1, 4'd5, 4'd9: size = 2;
      4'd2, 4'd10:      size = 4;
      default:          size = 0;
    endcase
    idx = addr >> 2;
    sh  = 8 * int'(addr % 4);
    if (size == 0 || (addr % size) != 0 || idx >= 1024) begin
      err = 1; lat = 1;
    end else if (op >= 4'd8) begin
      w = ref_mem[idx[9:0]];
      if (size == 4) mask = 32'hFFFFFFFF;
      else           mask = ((32'h1 << (8 * size)) - 1) << sh;
      wval = (w & ~mask) | ((wdata << sh) & mask);
      ref_mem[idx[9:0]] = wval;
      widx = idx; nwr = 1;
      lat = (size == 4) ? 2 : 3;
    end else begin
      v = ref_mem[idx[9:0]] >> sh;
      if (size == 1) begin
        v = v & 32'hFF;
        if (op < 4'd4 && v[7]) v = v | 32'hFFFFFF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (op < 4'd4 && v[15]) v = v | 32'hFFFF0000;
      end
      rdata = v; lat = 3;
    end
  endfunction

  // Issue one request from IDLE, measure cycles to resp_valid, then complete the handshake.
  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat, output int nwr);
    int w0;
    @(negedge clk);
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    w0 = wr_count;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    #1;
    nwr = wr_count - w0;
    rdata = resp_rdata;
    err = resp_error;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wval;
  } vec_t;

  vec_t tbl [16];

  // Run one request through the model and DUT and compare everything observable.
  task automatic run_checked(input string name, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] e_rdata, input logic e_err,
                             input int e_lat, input int e_nwr, input logic [31:0] e_waddr,
                             input logic [31:0] e_wval);
    logic [31:0] g_rdata;
    logic        g_err;
    int          g_lat, g_nwr;
    do_req(op, addr, wdata, g_rdata, g_err, g_lat, g_nwr);
    check32({name, " rdata"}, g_rdata, e_rdata);
    check32({name, " error"}, {31'b0, g_err}, {31'b0, e_err});
    check32({name, " latency"}, g_lat, e_lat);
    check32({name, " strobes"}, g_nwr, e_nwr);
    if (e_nwr == 1 && g_nwr == 1) begin
      check32({name, " wr addr"}, wr_addr_seen, e_waddr);
      check32({name, " wr data"}, wr_data_seen, e_wval);
    end
    $display("req op=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d wr=%0d",
             op, addr, wdata, g_rdata, g_err, g_lat, g_nwr);
  endtask

  initial begin
    logic [31:0] m_rdata, m_widx, m_wval;
    logic        m_err;
    int          m_lat, m_nwr, w0;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    reset_n = 1'b0; mem_clear = 1'b1;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check32("rst resp_valid", {31'b0, resp_valid}, 32'h0);
    check32("rst resp_rdata", resp_rdata, 32'h0);
    check32("rst resp_error", {31'b0, resp_error}, 32'h0);
    check32("rst mem_we", {31'b0, memWriteEnable}, 32'h0);
    check32("rst mem_addr", memAddress, 32'h0);
    check32("rst mem_din", memDataIn, 32'h0);
    reset_n = 1'b1; mem_clear = 1'b0;
    @(negedge clk);
    check32("rst req_ready", {31'b0, req_ready}, 32'h1);

    // Directed vectors.
    tbl[0]  = '{OP_SW,  32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'd4,    32'hDEADBEEF};
    tbl[1]  = '{OP_LB,  32'h13,   32'h0,        32'hFFFFFFDE, 1'b0, 3, 0, 32'h0,    32'h0};
    tbl[2]  = '{OP_LBU, 32'h13,   32'h0,        32'h000000DE, 1'b0, 3, 0, 32'h0,    32'h0};
    tbl[3]  = '{OP_LH,  32'h12,   32'h0,        32'hFFFFDEAD, 1'b0, 3, 0, 32'h0,    32'h0};
    tbl[4]  = '{OP_LHU, 32'h12,   32'h0,        32'h0000DEAD, 1'b0, 3, 0, 32'h0,    32'h0};
    tbl[5]  = '{OP_LW,  32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 3, 0, 32'h0,    32'h0};
    tbl[6]  = '{OP_SB,  32'h11,   32'h00000055, 32'h0,        1'b0, 3, 1, 32'd4,    32'hDEAD55EF};
    tbl[7]  = '{OP_SH,  32'h12,   32'h00001234, 32'h0,        1'b0, 3, 1, 32'd4,    32'h123455EF};
    tbl[8]  = '{OP_LW,  32'h10,   32'h0,        32'h123455EF, 1'b0, 3, 0, 32'h0,    32'h0};
    tbl[9]  = '{OP_LW,  32'h12,   32'h0,        32'h0,        1'b1, 1, 0, 32'h0,    32'h0};
    tbl[10] = '{OP_SH,  32'h11,   32'hFFFF,     32'h0,        1'b1, 1, 0, 32'h0,    32'h0};
    tbl[11] = '{OP_LW,  32'h1000, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0,    32'h0};
    tbl[12] = '{4'd3,   32'h10,   32'h0,        32'h0,        1'b1, 1, 0, 32'h0,    32'h0};
    tbl[13] = '{OP_LB,  32'h10,   32'h0,        32'hFFFFFFEF, 1'b0, 3, 0, 32'h0,    32'h0};
    tbl[14] = '{OP_SB,  32'hFFF,  32'h000000A5, 32'h0,        1'b0, 3, 1, 32'd1023, 32'hA5000000};
    tbl[15] = '{OP_LBU, 32'hFFF,  32'h0,        32'h000000A5, 1'b0, 3, 0, 32'h0,    32'h0};
    for (int i = 0; i < 16; i++) begin
      model(tbl[i].op, tbl[i].addr, tbl[i].wdata, m_rdata, m_err, m_lat, m_nwr, m_widx, m_wval);
      run_checked($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
                  tbl[i].err, tbl[i].lat, tbl[i].nwr, tbl[i].waddr, tbl[i].wval);
    end

    // Response back-pressure: hold resp_ready low and offer a competing request.
    @(negedge clk);
    w0 = wr_count;
    req_op = OP_LW; req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    m_lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (resp_valid === 1'b1) begin m_lat = k; break; end
    end
    check32("stall latency", m_lat, 3);
    req_op = OP_SW; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check32("stall resp_valid", {31'b0, resp_valid}, 32'h1);
      check32("stall rdata", resp_rdata, 32'h123455EF);
      check32("stall error", {31'b0, resp_error}, 32'h0);
      check32("stall req_ready", {31'b0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check32("stall post req_ready", {31'b0, req_ready}, 32'h1);
    check32("stall post resp_valid", {31'b0, resp_valid}, 32'h0);
    check32("stall no write", wr_count - w0, 0);
    $display("stall sequence: LW held 5 cycles, competing SW ignored");
    model(OP_SW, 32'h20, 32'hCAFEF00D, m_rdata, m_err, m_lat, m_nwr, m_widx, m_wval);
    run_checked("post-stall SW", OP_SW, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, 32'd8, 32'hCAFEF00D);

    // Reset during the RD cycle of an SB: no write, request discarded.
    @(negedge clk);
    w0 = wr_count;
    req_op = OP_SB; req_addr = 32'h11; req_wdata = 32'h77; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check32("abort resp_valid", {31'b0, resp_valid}, 32'h0);
    @(negedge clk);
    check32("abort req_ready", {31'b0, req_ready}, 32'h1);
    check32("abort resp_valid2", {31'b0, resp_valid}, 32'h0);
    repeat (3) @(negedge clk);
    check32("abort no write", wr_count - w0, 0);
    $display("reset-abort sequence: SB discarded in RD");
    model(OP_LW, 32'h10, 32'h0, m_rdata, m_err, m_lat, m_nwr, m_widx, m_wval);
    run_checked("abort readback", OP_LW, 32'h10, 32'h0, m_rdata, m_err, m_lat, m_nwr, m_widx, m_wval);

    // Random requests against the model.
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  op;
      logic [31:0] addr, wdata;
      op    = 4'($urandom_range(0, 15));
      wdata = $urandom;
      if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h00001000;
      else                           addr = $urandom_range(0, 63);
      model(op, addr, wdata, m_rdata, m_err, m_lat, m_nwr, m_widx, m_wval);
      run_checked($sformatf("rnd%0d", n), op, addr, wdata, m_rdata, m_err, m_lat, m_nwr, m_widx, m_wval);
    end

    // Final memory image must match the model.
    @(negedge clk);
    for (int i = 0; i < 1024; i++) check32($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
